// File: rtl/rule_matcher_if.sv
// Bundles the packet header, rule range fields and match results exchanged
// between the classifier tree walker and the rule matcher.
interface rule_matcher_if #(
   parameter int IP_W    = 32,
   parameter int PORT_W  = 16,
   parameter int PROTO_W = 8
);
   logic               in_valid;
   logic [IP_W-1:0]    pkt_src_ip;
   logic [IP_W-1:0]    pkt_dst_ip;
   logic [PORT_W-1:0]  pkt_src_port;
   logic [PORT_W-1:0]  pkt_dst_port;
   logic [PROTO_W-1:0] pkt_protocol;

   logic [IP_W-1:0]    rule_start_src_ip;
   logic [IP_W-1:0]    rule_start_dst_ip;
   logic [PORT_W-1:0]  rule_start_src_port;
   logic [PORT_W-1:0]  rule_start_dst_port;
   logic [PROTO_W-1:0] rule_start_protocol;

   // Upper bounds are exclusive and one bit wider so a full range is expressible
   logic [IP_W:0]      rule_last_src_ip;
   logic [IP_W:0]      rule_last_dst_ip;
   logic [PORT_W:0]    rule_last_src_port;
   logic [PORT_W:0]    rule_last_dst_port;
   logic [PROTO_W:0]   rule_last_protocol;

   logic               matched_comb;
   logic               out_valid;
   logic               matched;
   logic [4:0]         field_match;

   modport master (
      output in_valid, pkt_src_ip, pkt_dst_ip, pkt_src_port, pkt_dst_port, pkt_protocol,
      output rule_start_src_ip, rule_start_dst_ip, rule_start_src_port,
      output rule_start_dst_port, rule_start_protocol,
      output rule_last_src_ip, rule_last_dst_ip, rule_last_src_port,
      output rule_last_dst_port, rule_last_protocol,
      input  matched_comb, out_valid, matched, field_match
   );

   modport slave (
      input  in_valid, pkt_src_ip, pkt_dst_ip, pkt_src_port, pkt_dst_port, pkt_protocol,
      input  rule_start_src_ip, rule_start_dst_ip, rule_start_src_port,
      input  rule_start_dst_port, rule_start_protocol,
      input  rule_last_src_ip, rule_last_dst_ip, rule_last_src_port,
      input  rule_last_dst_port, rule_last_protocol,
      output matched_comb, out_valid, matched, field_match
   );
endinterface

// File: rtl/rule_matcher.sv
// Five-tuple hyper-rectangle check: combinational match plus a one-cycle
// registered copy (match, per-field hits, valid) for the pipelined tree walk.
module rule_matcher #(
   parameter int IP_W    = 32,
   parameter int PORT_W  = 16,
   parameter int PROTO_W = 8
) (
   input logic           clk,
   input logic           reset,
   rule_matcher_if.slave bus
);

   logic [IP_W-1:0]    pktSrcIp, pktDstIp, startSrcIp, startDstIp;
   logic [PORT_W-1:0]  pktSrcPort, pktDstPort, startSrcPort, startDstPort;
   logic [PROTO_W-1:0] pktProto, startProto;
   logic [IP_W:0]      lastSrcIp, lastDstIp;
   logic [PORT_W:0]    lastSrcPort, lastDstPort;
   logic [PROTO_W:0]   lastProto;

   assign pktSrcIp     = bus.pkt_src_ip;
   assign pktDstIp     = bus.pkt_dst_ip;
   assign pktSrcPort   = bus.pkt_src_port;
   assign pktDstPort   = bus.pkt_dst_port;
   assign pktProto     = bus.pkt_protocol;
   assign startSrcIp   = bus.rule_start_src_ip;
   assign startDstIp   = bus.rule_start_dst_ip;
   assign startSrcPort = bus.rule_start_src_port;
   assign startDstPort = bus.rule_start_dst_port;
   assign startProto   = bus.rule_start_protocol;
   assign lastSrcIp    = bus.rule_last_src_ip;
   assign lastDstIp    = bus.rule_last_dst_ip;
   assign lastSrcPort  = bus.rule_last_src_port;
   assign lastDstPort  = bus.rule_last_dst_port;
   assign lastProto    = bus.rule_last_protocol;

   // One comparator pair per field, shared by the comb and registered outputs
   logic [4:0] hit;

   always_comb begin
      hit[0] = (pktSrcIp   >= startSrcIp)   && ({1'b0, pktSrcIp}   < lastSrcIp);
      hit[1] = (pktDstIp   >= startDstIp)   && ({1'b0, pktDstIp}   < lastDstIp);
      hit[2] = (pktSrcPort >= startSrcPort) && ({1'b0, pktSrcPort} < lastSrcPort);
      hit[3] = (pktDstPort >= startDstPort) && ({1'b0, pktDstPort} < lastDstPort);
      hit[4] = (pktProto   >= startProto)   && ({1'b0, pktProto}   < lastProto);
   end

   assign bus.matched_comb = &hit;

   logic       out_valid_q, out_valid_d;
   logic       matched_q, matched_d;
   logic [4:0] field_match_q, field_match_d;

   // Results only update on a valid pair; otherwise the last result is held
   always_comb begin
      out_valid_d   = bus.in_valid;
      matched_d     = matched_q;
      field_match_d = field_match_q;
      if (bus.in_valid) begin
         matched_d     = &hit;
         field_match_d = hit;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q   <= 1'b0;
         matched_q     <= 1'b0;
         field_match_q <= 5'b0;
      end else begin
         out_valid_q   <= out_valid_d;
         matched_q     <= matched_d;
         field_match_q <= field_match_d;
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.matched     = matched_q;
   assign bus.field_match = field_match_q;

endmodule

// File: tb/tb_rule_matcher.sv
// Self-checking bench for rule_matcher: directed literal cases plus a
// randomized run compared every cycle against an arithmetic range model.
module tb_rule_matcher;

   localparam int IP_W    = 32;
   localparam int PORT_W  = 16;
   localparam int PROTO_W = 8;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   rule_matcher_if #(.IP_W(IP_W), .PORT_W(PORT_W), .PROTO_W(PROTO_W)) bus ();

   rule_matcher #(.IP_W(IP_W), .PORT_W(PORT_W), .PROTO_W(PROTO_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A field hits when start <= pkt < last, evaluated as plain integers
   function automatic logic hitOf(longint unsigned p, longint unsigned s, longint unsigned l);
      return (p >= s) && (p < l);
   endfunction

   function automatic logic [4:0] modelHits();
      logic [4:0] h;
      h[0] = hitOf(bus.pkt_src_ip,   bus.rule_start_src_ip,   bus.rule_last_src_ip);
      h[1] = hitOf(bus.pkt_dst_ip,   bus.rule_start_dst_ip,   bus.rule_last_dst_ip);
      h[2] = hitOf(bus.pkt_src_port, bus.rule_start_src_port, bus.rule_last_src_port);
      h[3] = hitOf(bus.pkt_dst_port, bus.rule_start_dst_port, bus.rule_last_dst_port);
      h[4] = hitOf(bus.pkt_protocol, bus.rule_start_protocol, bus.rule_last_protocol);
      return h;
   endfunction

   task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   // Expected registered outputs, advanced by the clock from the model hits
   logic       expValid = 1'b0;
   logic       expMatched = 1'b0;
   logic [4:0] expFm = 5'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         expValid   <= 1'b0;
         expMatched <= 1'b0;
         expFm      <= 5'b0;
      end else begin
         expValid <= bus.in_valid;
         if (bus.in_valid) begin
            expFm      <= modelHits();
            expMatched <= (modelHits() == 5'b11111);
         end
      end
   end

   always @(negedge clk) begin
      checkOutput("cmp_comb",      {4'b0, bus.matched_comb}, {4'b0, (modelHits() == 5'b11111)});
      checkOutput("cmp_out_valid", {4'b0, bus.out_valid},    {4'b0, expValid});
      checkOutput("cmp_matched",   {4'b0, bus.matched},      {4'b0, expMatched});
      checkOutput("cmp_field",     bus.field_match,          expFm);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setWildcard();
      bus.rule_start_src_ip   = '0;
      bus.rule_start_dst_ip   = '0;
      bus.rule_start_src_port = '0;
      bus.rule_start_dst_port = '0;
      bus.rule_start_protocol = '0;
      bus.rule_last_src_ip    = 33'h1_0000_0000;
      bus.rule_last_dst_ip    = 33'h1_0000_0000;
      bus.rule_last_src_port  = 17'h1_0000;
      bus.rule_last_dst_port  = 17'h1_0000;
      bus.rule_last_protocol  = 9'h100;
   endtask

   task automatic setPkt(input logic [31:0] sip, input logic [31:0] dip,
                         input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] pr);
      bus.pkt_src_ip   = sip;
      bus.pkt_dst_ip   = dip;
      bus.pkt_src_port = sp;
      bus.pkt_dst_port = dp;
      bus.pkt_protocol = pr;
   endtask

   task automatic randField(input int w, output longint unsigned p,
                            output longint unsigned s, output longint unsigned l);
      longint unsigned full, mask, r;
      full = 64'd1 << w;
      mask = full - 64'd1;
      r    = {$urandom, $urandom};
      p    = r & mask;
      case ($urandom_range(0, 3))
         0: begin
            s = 0;
            l = full;
         end
         1: begin
            r = longint'($urandom_range(0, 3));
            s = (p > r) ? p - r : 64'd0;
            l = p + longint'($urandom_range(0, 3));
         end
         2: begin
            s = {$urandom, $urandom} & mask;
            l = {$urandom, $urandom} & ((full << 1) - 64'd1);
         end
         default: begin
            s = (p + longint'($urandom_range(0, 2)) - 64'd1) & mask;
            l = s + 64'd1;
         end
      endcase
   endtask

   task automatic applyStimulus();
      longint unsigned p, s, l;
      bus.in_valid = ($urandom_range(0, 3) != 0);
      reset        = ($urandom_range(0, 39) != 0);
      randField(IP_W, p, s, l);
      bus.pkt_src_ip = p[IP_W-1:0]; bus.rule_start_src_ip = s[IP_W-1:0]; bus.rule_last_src_ip = l[IP_W:0];
      randField(IP_W, p, s, l);
      bus.pkt_dst_ip = p[IP_W-1:0]; bus.rule_start_dst_ip = s[IP_W-1:0]; bus.rule_last_dst_ip = l[IP_W:0];
      randField(PORT_W, p, s, l);
      bus.pkt_src_port = p[PORT_W-1:0]; bus.rule_start_src_port = s[PORT_W-1:0]; bus.rule_last_src_port = l[PORT_W:0];
      randField(PORT_W, p, s, l);
      bus.pkt_dst_port = p[PORT_W-1:0]; bus.rule_start_dst_port = s[PORT_W-1:0]; bus.rule_last_dst_port = l[PORT_W:0];
      randField(PROTO_W, p, s, l);
      bus.pkt_protocol = p[PROTO_W-1:0]; bus.rule_start_protocol = s[PROTO_W-1:0]; bus.rule_last_protocol = l[PROTO_W:0];
   endtask

   localparam logic [31:0] PktSrc = 32'h0A00_0001;
   localparam logic [31:0] PktDst = 32'hC0A8_0101;

   initial begin
      logic [2:0] protoExp;
      reset = 1'b0;
      bus.in_valid = 1'b1;
      setWildcard();
      setPkt(PktSrc, PktDst, 16'd80, 16'd443, 8'd6);

      // Reset held with valid inputs
      tick();
      tick();
      checkOutput("rst_out_valid", {4'b0, bus.out_valid}, 5'b0);
      checkOutput("rst_matched",   {4'b0, bus.matched},   5'b0);
      checkOutput("rst_field",     bus.field_match,       5'b0);
      checkOutput("wild_comb",     {4'b0, bus.matched_comb}, 5'b1);

      reset = 1'b1;
      tick();
      checkOutput("wild_out_valid", {4'b0, bus.out_valid}, 5'b1);
      checkOutput("wild_matched",   {4'b0, bus.matched},   5'b1);
      checkOutput("wild_field",     bus.field_match,       5'b11111);

      // Single-point dst port then empty dst port
      bus.rule_start_dst_port = 16'd443;
      bus.rule_last_dst_port  = 17'd444;
      #1 checkOutput("point_comb", {4'b0, bus.matched_comb}, 5'b1);
      tick();
      checkOutput("point_matched", {4'b0, bus.matched}, 5'b1);
      bus.rule_last_dst_port = 17'd443;
      #1 checkOutput("empty_comb", {4'b0, bus.matched_comb}, 5'b0);
      tick();
      checkOutput("empty_matched", {4'b0, bus.matched}, 5'b0);
      checkOutput("empty_field",   bus.field_match,     5'b10111);

      // Protocol boundaries around a single-point range
      setWildcard();
      bus.rule_start_protocol = 8'd6;
      bus.rule_last_protocol  = 9'd7;
      protoExp = 3'b010;
      for (int i = 0; i < 3; i++) begin
         bus.pkt_protocol = 8'(5 + i);
         #1 checkOutput("proto_comb", {4'b0, bus.matched_comb}, {4'b0, protoExp[i]});
         tick();
         checkOutput("proto_field4", {4'b0, bus.field_match[4]}, {4'b0, protoExp[i]});
      end
      setPkt(32'hFFFF_FFFF, PktDst, 16'd80, 16'd443, 8'd6);
      tick();
      checkOutput("maxip_field", bus.field_match, 5'b11111);

      // Back-to-back alternating hit/miss
      setWildcard();
      setPkt(PktSrc, PktDst, 16'd80, 16'd443, 8'd6);
      bus.rule_start_dst_port = 16'd443;
      for (int i = 0; i < 4; i++) begin
         bus.rule_last_dst_port = (i % 2 == 0) ? 17'd444 : 17'd443;
         tick();
         checkOutput("b2b_valid",   {4'b0, bus.out_valid}, 5'b1);
         checkOutput("b2b_matched", {4'b0, bus.matched},   {4'b0, (i % 2 == 0)});
      end
      bus.rule_last_dst_port = 17'd444;
      tick();
      bus.in_valid = 1'b0;
      bus.rule_last_dst_port = 17'd443;
      tick();
      checkOutput("hold_valid",   {4'b0, bus.out_valid}, 5'b0);
      checkOutput("hold_matched", {4'b0, bus.matched},   5'b1);
      checkOutput("hold_field",   bus.field_match,       5'b11111);

      // Inverted src IP range
      bus.in_valid = 1'b1;
      setWildcard();
      bus.rule_start_src_ip = 32'd100;
      bus.rule_last_src_ip  = 33'd50;
      bus.pkt_src_ip        = 32'd75;
      tick();
      checkOutput("inv_matched", {4'b0, bus.matched}, 5'b0);
      checkOutput("inv_field",   bus.field_match,     5'b11110);

      // Asynchronous reset while a result is in flight
      setWildcard();
      tick();
      checkOutput("pre_rst_valid", {4'b0, bus.out_valid}, 5'b1);
      #2 reset = 1'b0;
      #1 checkOutput("async_rst_valid",   {4'b0, bus.out_valid}, 5'b0);
      checkOutput("async_rst_matched", {4'b0, bus.matched},   5'b0);
      tick();
      reset = 1'b1;
      tick();
      checkOutput("release_matched", {4'b0, bus.matched}, 5'b1);
      checkOutput("release_field",   bus.field_match,     5'b11111);

      for (int n = 0; n < 600; n++) begin
         applyStimulus();
         tick();
      end
      reset = 1'b1;
      tick();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
